// File: rtl/generic_banked_tsmc_sram_if.sv
`default_nettype none
// ============================================================================
//  Module   : generic_banked_tsmc_sram_if
//  Purpose  : Access bus for the banked SRAM model (request, data, status).
//  Revision : 1.0
// ============================================================================
interface generic_banked_tsmc_sram_if #(
    parameter int WIDTH         = 128,
    parameter int ADDRESS_WIDTH = 12,
    parameter int MASK_WIDTH    = 16
);
    logic                     CEB;
    logic                     WEB;
    logic [ADDRESS_WIDTH-1:0] A;
    logic [WIDTH-1:0]         D;
    logic [MASK_WIDTH-1:0]    M;
    logic                     CLR;
    logic                     READY;
    logic [WIDTH-1:0]         Q;
    logic                     Q_VALID;

    modport master (
        output CEB, WEB, A, D, M, CLR,
        input  READY, Q, Q_VALID
    );

    modport slave (
        input  CEB, WEB, A, D, M, CLR,
        output READY, Q, Q_VALID
    );
endinterface
`default_nettype wire

// File: rtl/generic_banked_tsmc_sram.sv
`default_nettype none
// ============================================================================
//  Module   : generic_banked_tsmc_sram
//  Purpose  : Banked single-port SRAM model with masks, read-first collisions,
//             optional output register and a row-parallel clear engine.
//  Revision : 1.0
// ============================================================================
module generic_banked_tsmc_sram #(
    parameter int WIDTH         = 128,
    parameter int NUM_ROWS      = 4096,
    parameter int NUM_BANKS     = 4,
    parameter int MASK_GRANULE  = 8,
    parameter int OUTPUT_REG    = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  wire logic CLK,
    input  wire logic RST,
    generic_banked_tsmc_sram_if.slave bus
);
    localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS);
    localparam int BANK_BITS     = $clog2(NUM_BANKS);
    localparam int ROWS_PER_BANK = NUM_ROWS / NUM_BANKS;
    localparam int MASK_WIDTH    = WIDTH / MASK_GRANULE;
    localparam int ROW_BITS      = ADDRESS_WIDTH - BANK_BITS;
    localparam int BANK_IDX_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS_PER_BANK - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;
    localparam logic [0:0] S_RESET = (INIT_ON_RESET != 0) ? S_CLEAR : S_RUN;

    logic [0:0]            state_q, state_d;
    logic [ROW_BITS-1:0]   cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [WIDTH-1:0]      q0_q, q0_d;
    logic                  qv0_q, qv0_d;

    logic                  clear_en;
    logic                  rd_en;
    logic                  wr_en;
    logic [BANK_IDX_W-1:0] bank_idx;
    logic [ROW_BITS-1:0]   row_idx;
    logic [WIDTH-1:0]      mexp;
    logic [WIDTH-1:0]      old_word;
    logic [WIDTH-1:0]      wr_word;

    logic [WIDTH-1:0]      mem_q [NUM_BANKS][ROWS_PER_BANK];

    generate
        if (BANK_BITS > 0) begin : g_multi_bank
            assign bank_idx = bus.A[BANK_BITS-1:0];
            assign row_idx  = bus.A[ADDRESS_WIDTH-1:BANK_BITS];
        end else begin : g_single_bank
            assign bank_idx = '0;
            assign row_idx  = bus.A;
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == LAST_ROW) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.CLR) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
        // READY is registered so it stays low through the reset cycle itself.
        ready_d = (state_d == S_RUN);
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        clear_en = (state_q == S_CLEAR) && !RST;
        rd_en    = ready_q && bus.CEB && !RST;
        wr_en    = rd_en && bus.WEB;
    end

    always_comb begin
        mexp = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            mexp[i*MASK_GRANULE +: MASK_GRANULE] = {MASK_GRANULE{bus.M[i]}};
        end
        old_word = mem_q[bank_idx][row_idx];
        wr_word  = (bus.D & mexp) | (old_word & ~mexp);
        q0_d     = rd_en ? old_word : q0_q;
        qv0_d    = rd_en;
    end

    // Memory array is deliberately not reset; only the clear engine zeroes it.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (clear_en) begin
                mem_q[b][cnt_q] <= '0;
            end else if (wr_en && (bank_idx == BANK_IDX_W'(b))) begin
                mem_q[b][row_idx] <= wr_word;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q0_q  <= '0;
            qv0_q <= 1'b0;
        end else begin
            q0_q  <= q0_d;
            qv0_q <= qv0_d;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] q1_q, q1_d;
            logic             qv1_q, qv1_d;

            always_comb begin
                q1_d  = qv0_q ? q0_q : q1_q;
                qv1_d = qv0_q;
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    q1_q  <= '0;
                    qv1_q <= 1'b0;
                end else begin
                    q1_q  <= q1_d;
                    qv1_q <= qv1_d;
                end
            end

            assign bus.Q       = q1_q;
            assign bus.Q_VALID = qv1_q;
        end else begin : g_out_direct
            assign bus.Q       = q0_q;
            assign bus.Q_VALID = qv0_q;
        end
    endgenerate

    assign bus.READY = ready_q;

endmodule
`default_nettype wire
